// File: rtl/button_pkg.sv
// Shared types and default timing constants for the push-button debouncers.
// The state encoding is internal; only the enum names are meant to be referenced.
package button_pkg;

  typedef enum logic [2:0] {
    S_RELEASED     = 3'd0,
    S_PRESS_PEND   = 3'd1,
    S_HELD         = 3'd2,
    S_REPEAT       = 3'd3,
    S_RELEASE_PEND = 3'd4
  } state_t;

  localparam int DEF_COUNT_W       = 8;
  localparam int DEF_STABLE_TICKS  = 3;
  localparam int DEF_REPEAT_DELAY  = 4;
  localparam int DEF_REPEAT_PERIOD = 2;

endpackage

// File: rtl/synchronizer.sv
// Two-flop single-bit synchronizer for asynchronous board inputs, 2 clk latency.
// Resets to 0 so a button held through reset still has to be debounced afterwards.
module synchronizer (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Tick-sampled push-button debouncer with registered level, press/release strobes and hold-to-repeat.
// Latency: 2 clk synchronizer, then STABLE_TICKS qualifying ticks; strobes appear 1 clk after the accepting tick.
module button_debouncer
  import button_pkg::*;
#(
  parameter int COUNT_W       = DEF_COUNT_W,
  parameter int STABLE_TICKS  = DEF_STABLE_TICKS,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic button_raw,
  output logic button_level,
  output logic pressed,
  output logic released
);

  localparam logic [COUNT_W-1:0] STAB_LAST   = COUNT_W'(STABLE_TICKS - 1);
  localparam logic [COUNT_W-1:0] DELAY_LAST  = COUNT_W'(REPEAT_DELAY - 1);
  localparam logic [COUNT_W-1:0] PERIOD_LAST = COUNT_W'(REPEAT_PERIOD - 1);
  localparam logic [COUNT_W-1:0] ONE         = COUNT_W'(1);
  localparam bit                 REPEAT_EN   = (REPEAT_DELAY != 0);

  logic               sync;
  state_t             state, state_nxt;
  logic [COUNT_W-1:0] stab_cnt, stab_nxt;
  logic [COUNT_W-1:0] rep_cnt, rep_nxt;
  logic               level_nxt, press_nxt, rel_nxt;

  synchronizer u_sync (
    .clk (clk),
    .rst (rst),
    .d   (button_raw),
    .q   (sync)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_RELEASED;
      stab_cnt     <= '0;
      rep_cnt      <= '0;
      button_level <= 1'b0;
      pressed      <= 1'b0;
      released     <= 1'b0;
    end else begin
      state        <= state_nxt;
      stab_cnt     <= stab_nxt;
      rep_cnt      <= rep_nxt;
      button_level <= level_nxt;
      pressed      <= press_nxt;
      released     <= rel_nxt;
    end
  end

  // A sync mismatch always wins over a same-cycle tick, so bounces never count.
  always_comb begin
    state_nxt = state;
    stab_nxt  = stab_cnt;
    rep_nxt   = rep_cnt;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    level_nxt = 1'b0;
    unique case (state)
      S_RELEASED: begin
        if (sync) state_nxt = S_PRESS_PEND;
      end
      S_PRESS_PEND: begin
        if (!sync) begin
          state_nxt = S_RELEASED;
        end else if (tick) begin
          if (stab_cnt == STAB_LAST) begin
            state_nxt = S_HELD;
            press_nxt = 1'b1;
          end else begin
            stab_nxt = stab_cnt + ONE;
          end
        end
      end
      S_HELD: begin
        if (!sync) begin
          state_nxt = S_RELEASE_PEND;
        end else if (REPEAT_EN && tick) begin
          if (rep_cnt == DELAY_LAST) begin
            state_nxt = S_REPEAT;
            press_nxt = 1'b1;
          end else begin
            rep_nxt = rep_cnt + ONE;
          end
        end
      end
      S_REPEAT: begin
        if (!sync) begin
          state_nxt = S_RELEASE_PEND;
        end else if (tick) begin
          if (rep_cnt == PERIOD_LAST) begin
            press_nxt = 1'b1;
            rep_nxt   = '0;
          end else begin
            rep_nxt = rep_cnt + ONE;
          end
        end
      end
      S_RELEASE_PEND: begin
        if (sync) begin
          state_nxt = S_HELD;
        end else if (tick) begin
          if (stab_cnt == STAB_LAST) begin
            state_nxt = S_RELEASED;
            rel_nxt   = 1'b1;
          end else begin
            stab_nxt = stab_cnt + ONE;
          end
        end
      end
      default: state_nxt = S_RELEASED;
    endcase

    if (state_nxt != state) begin
      stab_nxt = '0;
      rep_nxt  = '0;
    end
    level_nxt = (state_nxt == S_HELD) || (state_nxt == S_REPEAT) ||
                (state_nxt == S_RELEASE_PEND);
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Randomized and directed bench for button_debouncer: one instance with repeat, one with repeat disabled.
// A reference model derives expected strobes from the sync history and pushes them to per-instance queues.
module tb_button_debouncer;

  localparam int ST  = 3;
  localparam int PER = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic button_raw = 1'b0;
  logic lvl0, p0, r0, lvl1, p1, r1;

  always #5 clk = ~clk;

  button_debouncer #(.COUNT_W(8), .STABLE_TICKS(ST), .REPEAT_DELAY(4), .REPEAT_PERIOD(PER)) u_rep (
    .clk(clk), .rst(rst), .tick(tick), .button_raw(button_raw),
    .button_level(lvl0), .pressed(p0), .released(r0)
  );

  button_debouncer #(.COUNT_W(8), .STABLE_TICKS(ST), .REPEAT_DELAY(0), .REPEAT_PERIOD(PER)) u_norep (
    .clk(clk), .rst(rst), .tick(tick), .button_raw(button_raw),
    .button_level(lvl1), .pressed(p1), .released(r1)
  );

  typedef struct {
    int cyc;
    bit press;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   dly[2] = '{4, 0};
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   tick_cnt = 0;
  int   n_p[2] = '{0, 0};
  int   n_r[2] = '{0, 0};
  int   tick_mode = 0;
  int   phase = 0;

  // Reference model state: accepted level, qualifying-tick run, ticks held since acceptance.
  bit   h1 = 1'b0, h2 = 1'b0, sprev = 1'b0;
  bit   mlvl[2] = '{1'b0, 1'b0};
  int   run[2] = '{0, 0};
  int   hold[2] = '{0, 0};

  task automatic push_exp(input int i, input bit press);
    exp_t e;
    e.cyc = cyc;
    e.press = press;
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // A new value is accepted once STABLE_TICKS ticks have been seen while the synchronized
  // input disagreed with the accepted level on both that cycle and the one before.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      h1 = 1'b0; h2 = 1'b0; sprev = 1'b0;
      for (int i = 0; i < 2; i++) begin
        mlvl[i] = 1'b0; run[i] = 0; hold[i] = 0;
      end
      q0.delete();
      q1.delete();
    end else begin
      bit snow;
      cyc++;
      if (tick) tick_cnt++;
      snow = h2;
      h2 = h1;
      h1 = button_raw;
      for (int i = 0; i < 2; i++) begin
        if (mlvl[i]) begin
          if (!snow) hold[i] = 0;
          else if (tick && sprev && dly[i] != 0) begin
            hold[i]++;
            if (hold[i] == dly[i] || (hold[i] > dly[i] && (hold[i] - dly[i]) % PER == 0))
              push_exp(i, 1'b1);
          end
        end
        if (snow == mlvl[i]) begin
          run[i] = 0;
        end else if (tick && sprev != mlvl[i]) begin
          run[i]++;
          if (run[i] == ST) begin
            push_exp(i, !mlvl[i]);
            mlvl[i] = !mlvl[i];
            run[i] = 0;
            hold[i] = 0;
          end
        end
      end
      sprev = snow;
    end
  end

  task automatic cmp(input string name, input int i, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s inst%0d cyc=%0d got=%0d want=%0d", name, i, cyc, got, want);
    end
  endtask

  // Monitor: pops whatever the model expects for this cycle and compares every output.
  always @(negedge clk) begin
    if (rst) begin
      bit ep[2];
      bit er[2];
      exp_t e;
      ep = '{1'b0, 1'b0};
      er = '{1'b0, 1'b0};
      while (q0.size() > 0) begin
        e = q0.pop_front();
        if (e.press) ep[0] = 1'b1; else er[0] = 1'b1;
      end
      while (q1.size() > 0) begin
        e = q1.pop_front();
        if (e.press) ep[1] = 1'b1; else er[1] = 1'b1;
      end
      cmp("pressed", 0, int'(p0), int'(ep[0]));
      cmp("released", 0, int'(r0), int'(er[0]));
      cmp("button_level", 0, int'(lvl0), int'(mlvl[0]));
      cmp("pressed", 1, int'(p1), int'(ep[1]));
      cmp("released", 1, int'(r1), int'(er[1]));
      cmp("button_level", 1, int'(lvl1), int'(mlvl[1]));
      if (p0) n_p[0]++;
      if (r0) n_r[0]++;
      if (p1) n_p[1]++;
      if (r1) n_r[1]++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      case (tick_mode)
        0: begin
          tick = (phase == 0);
          phase = (phase == 4) ? 0 : phase + 1;
        end
        1: tick = ($urandom_range(0, 3) == 0);
        2: tick = 1'b1;
        default: tick = 1'b0;
      endcase
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_evt(input int i, input bit rel, input int budget);
    int start;
    bit ok;
    start = rel ? n_r[i] : n_p[i];
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if ((rel ? n_r[i] : n_p[i]) != start) begin
        ok = 1'b1;
        break;
      end
    end
    cmp(rel ? "wait_released" : "wait_pressed", i, int'(ok), 1);
  endtask

  task automatic wait_ticks(input int target, input int budget);
    int k;
    k = 0;
    while (tick_cnt < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    cmp("wait_ticks", 0, int'(tick_cnt >= target), 1);
  endtask

  task automatic check_reset_outputs();
    cmp("rst_level", 0, int'(lvl0), 0);
    cmp("rst_pressed", 0, int'(p0), 0);
    cmp("rst_released", 0, int'(r0), 0);
    cmp("rst_level", 1, int'(lvl1), 0);
    cmp("rst_pressed", 1, int'(p1), 0);
    cmp("rst_released", 1, int'(r1), 0);
  endtask

  initial begin
    int bp0, bp1, br0, br1, t0;
    cycles(3);
    check_reset_outputs();
    rst = 1'b1;
    cycles(10);

    // Clean press followed by twelve ticks of hold
    bp0 = n_p[0]; bp1 = n_p[1]; br0 = n_r[0];
    button_raw = 1'b1;
    wait_evt(0, 1'b0, 100);
    cmp("level_after_press", 0, int'(lvl0), 1);
    t0 = tick_cnt;
    wait_ticks(t0 + 12, 200);
    cmp("hold_press_count", 0, n_p[0] - bp0, 6);
    cmp("hold_press_count", 1, n_p[1] - bp1, 1);
    cmp("hold_no_release", 0, n_r[0] - br0, 0);

    // Short low glitch while held, then clean release
    br0 = n_r[0];
    button_raw = 1'b0;
    cycles(5);
    button_raw = 1'b1;
    cycles(30);
    cmp("glitch_no_release", 0, n_r[0] - br0, 0);
    button_raw = 1'b0;
    wait_evt(0, 1'b1, 100);
    cmp("level_after_release", 0, int'(lvl0), 0);
    cycles(20);

    // Press bounce spanning at most two ticks
    bp0 = n_p[0]; bp1 = n_p[1];
    button_raw = 1'b1;
    cycles(8);
    button_raw = 1'b0;
    cycles(20);
    cmp("bounce_no_press", 0, n_p[0] - bp0, 0);
    cmp("bounce_no_press", 1, n_p[1] - bp1, 0);

    // Asynchronous reset while repeating with the button held
    button_raw = 1'b1;
    wait_evt(0, 1'b0, 100);
    cycles(30);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs();
    cycles(3);
    br0 = n_r[0];
    rst = 1'b1;
    wait_evt(0, 1'b0, 100);
    cmp("post_reset_no_release", 0, n_r[0] - br0, 0);

    // Long hold with repeat disabled
    button_raw = 1'b0;
    cycles(40);
    bp1 = n_p[1]; br1 = n_r[1];
    button_raw = 1'b1;
    wait_evt(1, 1'b0, 100);
    t0 = tick_cnt;
    wait_ticks(t0 + 20, 300);
    cmp("norep_press_count", 1, n_p[1] - bp1, 1);
    button_raw = 1'b0;
    cycles(40);
    cmp("norep_release_count", 1, n_r[1] - br1, 1);

    // Randomized segments across tick modes
    tick_mode = 1;
    for (int s = 0; s < 80; s++) begin
      button_raw = 1'($urandom_range(0, 1));
      cycles($urandom_range(1, 25));
    end
    tick_mode = 2;
    for (int s = 0; s < 15; s++) begin
      button_raw = 1'($urandom_range(0, 1));
      cycles($urandom_range(1, 12));
    end
    tick_mode = 3;
    for (int s = 0; s < 10; s++) begin
      button_raw = 1'($urandom_range(0, 1));
      cycles($urandom_range(1, 10));
    end
    tick_mode = 0;
    for (int s = 0; s < 40; s++) begin
      button_raw = 1'($urandom_range(0, 1));
      cycles($urandom_range(1, 30));
    end
    button_raw = 1'b0;
    cycles(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Consumes the periodic one-cycle `out` pulse of the etch-a-sketch pulse generator as its sampling tick.
- Debounces one raw push-button and produces a clean level plus one-cycle press and release strobes.
- Optional hold-to-repeat re-issues press strobes while the button is held, so the cursor keeps moving.
- Sits between the board buttons and the cursor position counters.

Parameters:
- COUNT_W, 8: width of internal tick counters. All tick-count parameters must fit in COUNT_W bits.
- STABLE_TICKS, 3: consecutive ticks an input must hold a new value before it is accepted. Must be >= 1.
- REPEAT_DELAY, 4: ticks after an accepted press before the first repeat strobe. 0 disables repeat entirely.
- REPEAT_PERIOD, 2: ticks between successive repeat strobes. Must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  sampling strobe, one clk cycle wide, driven from the pulse generator `out`.
- button_raw  in  1  asynchronous raw button, active-high.
- button_level  out  1  debounced button state.
- pressed  out  1  one-cycle strobe on an accepted press and on each repeat.
- released  out  1  one-cycle strobe on an accepted release.

Behaviour:
- Reset:
  - Asserting rst (low) immediately clears all flops, independent of clk: synchronizer, state = S_RELEASED, counters = 0, all outputs = 0.
  - No strobe is emitted on reset entry or exit.
  - A button already held when rst deasserts must complete a full debounce before `pressed` fires.
- Synchronizer: button_raw passes through a 2-flop synchronizer; `sync` is its output. This adds 2 clk cycles of latency.
- Counters:
  - stab_cnt counts qualifying ticks in the pending states.
  - rep_cnt counts ticks in the held states.
  - Both clear on every state change.
  - Ticks arriving in any state that does not count are ignored.
- FSM (all outputs registered):
  - S_RELEASED: button_level = 0. If sync = 1, go to S_PRESS_PEND.
  - S_PRESS_PEND: button_level = 0.
    - If sync = 0 (checked every clk, not only on ticks), return to S_RELEASED. This is a bounce; no strobe.
    - Else on tick, stab_cnt++. On the tick where stab_cnt == STABLE_TICKS-1, go to S_HELD and assert `pressed` for the following cycle.
  - S_HELD: button_level = 1.
    - If sync = 0, go to S_RELEASE_PEND.
    - Else, if REPEAT_DELAY != 0, rep_cnt++ on each tick. On the tick where rep_cnt == REPEAT_DELAY-1, assert `pressed` and go to S_REPEAT.
  - S_REPEAT: button_level = 1.
    - If sync = 0, go to S_RELEASE_PEND.
    - Else on tick, rep_cnt++. On the tick where rep_cnt == REPEAT_PERIOD-1, assert `pressed` and clear rep_cnt.
  - S_RELEASE_PEND: button_level = 1.
    - If sync = 1, go to S_HELD; the repeat timing restarts from REPEAT_DELAY. No strobe.
    - Else on tick, stab_cnt++. On the tick where stab_cnt == STABLE_TICKS-1, go to S_RELEASED and assert `released`.
- Strobe timing: `pressed` and `released` are high for exactly one clk cycle, the cycle after the clock edge that samples the qualifying tick. The two never assert together.
- button_level timing: changes on the same edge that raises the corresponding strobe.
- Same-cycle sync change and tick: a sync mismatch and a tick in the same cycle resolve as the bounce/abort transition; the tick is not counted.
- Counter wrap: counters never wrap, because every comparison resets them or changes state first.
- Tick held high: the block stays functional if tick is high for consecutive cycles; each cycle counts as one tick.
- Tick always low: if tick never pulses, states can still abort on sync changes, but nothing is ever accepted.

Decomposition:
- Package button_pkg holds the state enum (S_RELEASED, S_PRESS_PEND, S_HELD, S_REPEAT, S_RELEASE_PEND) as a typedef, plus the default parameter constants.
- One sub-module, `synchronizer`: a 2-flop, 1-bit synchronizer with clk and asynchronous active-low rst, resetting to 0. It is reusable for the other buttons.
- The FSM and counters stay in button_debouncer.

Test Plan:
All scenarios use STABLE_TICKS=3, REPEAT_DELAY=4, REPEAT_PERIOD=2, with tick every 5 clks.
1. Clean press: raw goes 0->1 and stays high -> exactly one `pressed` strobe, 1 clk after the 3rd tick following sync=1; button_level rises on the same edge; `released` stays 0.
2. Press bounce: raw high across 2 ticks, then low -> no `pressed`; button_level stays 0; state returns to S_RELEASED.
3. Hold-repeat: hold raw for 12 ticks after the accepted press -> repeat strobes 1 clk after ticks 4, 6, 8, 10 and 12 after acceptance, i.e. 6 `pressed` strobes in total.
4. Release:
   - A 1-tick low glitch while held -> no `released`; button_level stays 1; repeat timing restarts.
   - A clean release -> one `released` strobe after the 3rd tick; button_level drops to 0.
5. Async reset: pull rst low mid-S_REPEAT, between clk edges, with raw still high -> outputs 0 immediately. After rst deasserts, `pressed` fires only after sync plus 3 ticks; no spurious `released`.
6. Repeat disabled: with REPEAT_DELAY=0, hold raw for 20 ticks -> exactly one `pressed` strobe, then one `released` strobe on release.
